// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding and load-use hazard unit for a five-stage pipeline. Destination
// tags from each decoded ID instruction are tracked through internal EX, MEM
// and WB stage records. From these records the unit derives:
//   - the EX-stage operand mux selects, and
//   - a one-cycle load-use stall request.
//
// Optional feature, enabled by defining FWD_RF_BYPASS_EN:
//   WB->ID register-file bypass on id_bypass_o. When the macro is undefined,
//   id_bypass_o is tied to zero and no comparators are built.
module fwd_hazard_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr_i,
  input  logic [NUM_SRC-1:0]          id_src_used_i,
  input  logic [ADDR_W-1:0]           id_rd_addr_i,
  input  logic                        id_regwrite_i,
  input  logic                        id_memread_i,
  input  logic                        flush_i,
  output logic [2*NUM_SRC-1:0]        ex_sel_o,
  output logic                        stall_o,
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [NUM_SRC-1:0]          id_bypass_o
);

  // Destination record shared by all stages.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
  } dst_t;

  // The EX record also carries memread, plus the source operands.
  // A load only matters while it is in EX, so memread is not kept in MEM/WB.
  dst_t                      ex_q,   ex_d;
  logic                      ex_memread_q, ex_memread_d;
  logic [NUM_SRC*ADDR_W-1:0] ex_src_q,  ex_src_d;
  logic [NUM_SRC-1:0]        ex_used_q, ex_used_d;
  dst_t                      mem_q;
  dst_t                      wb_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic mem_writes, wb_writes, ex_is_load;

  // A stage writes only with a real, non-x0 destination, so x0 never forwards.
  assign mem_writes = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
  assign wb_writes  = wb_q.valid  && wb_q.regwrite  && (wb_q.rd  != '0);
  assign ex_is_load = ex_q.valid  && ex_memread_q && ex_q.regwrite && (ex_q.rd != '0);

  // EX operand selects from stage registers only; the MEM match beats the WB match.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ex_sel_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_q.valid && ex_used_q[k]) begin
        if (mem_writes && (mem_q.rd == ex_src_q[k*ADDR_W +: ADDR_W]))
          ex_sel_o[2*k +: 2] = 2'b10;
        else if (wb_writes && (wb_q.rd == ex_src_q[k*ADDR_W +: ADDR_W]))
          ex_sel_o[2*k +: 2] = 2'b01;
      end
    end
  end

  // Load-use stall: a used ID source reads the destination of the load in EX.
  // Flush suppresses the stall.
  always_comb begin
    stall_o = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used_i[k] && (id_src_addr_i[k*ADDR_W +: ADDR_W] == ex_q.rd))
        stall_o = 1'b1;
    end
    stall_o = stall_o && id_valid_i && !flush_i && ex_is_load;
  end

  // Next EX record and the saturating stall counter.
  always_comb begin
    ex_d         = '0;
    ex_memread_d = 1'b0;
    ex_src_d     = '0;
    ex_used_d    = '0;
    if (id_valid_i && !stall_o && !flush_i) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd_addr_i;
      ex_d.regwrite  = id_regwrite_i;
      ex_memread_d   = id_memread_i;
      ex_src_d       = id_src_addr_i;
      ex_used_d      = id_src_used_i;
    end
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Stage register advance: MEM and WB always move; EX loads or bubbles.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    if (rst_i) begin
      ex_q         <= '0;
      ex_memread_q <= 1'b0;
      ex_src_q     <= '0;
      ex_used_q    <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      cnt_q        <= '0;
    end else begin
      ex_q         <= ex_d;
      ex_memread_q <= ex_memread_d;
      ex_src_q     <= ex_src_d;
      ex_used_q    <= ex_used_d;
      mem_q        <= ex_q;
      wb_q         <= mem_q;
      cnt_q        <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

`ifdef FWD_RF_BYPASS_EN
  // WB->ID bypass covers distance 3 when the register file lacks write-through.
  always_comb begin
    id_bypass_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      id_bypass_o[k] = id_valid_i && id_src_used_i[k] && wb_writes &&
                       (wb_q.rd == id_src_addr_i[k*ADDR_W +: ADDR_W]);
    end
  end
`else
  assign id_bypass_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed testbench for fwd_hazard_unit (ADDR_W=5, NUM_SRC=2, CNT_W=16).
// Inputs change 1ns after a rising edge; outputs are sampled in that window.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [9:0] id_src_addr;
  logic [1:0] id_src_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic [3:0] ex_sel;
  logic       stall;
  logic [15:0] stall_cnt;
  logic [1:0] id_bypass;

  int passed = 0;
  int total  = 0;

`ifdef FWD_RF_BYPASS_EN
  localparam logic [1:0] BYP_EXP = 2'b01;
`else
  localparam logic [1:0] BYP_EXP = 2'b00;
`endif

  fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_src_addr_i (id_src_addr),
    .id_src_used_i (id_src_used),
    .id_rd_addr_i  (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .ex_sel_o      (ex_sel),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt),
    .id_bypass_o   (id_bypass)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_used = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    nop();
    tick();
    total++; if (ex_sel !== 4'b0000) $display("FAIL reset_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); else passed++;
    total++; if (id_bypass !== 2'b00) $display("FAIL reset_bypass: got %b expected 00", id_bypass); else passed++;
    tick();
    rst = 1'b0;
    drain();
  endtask

  task automatic test_alu_chain();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0); tick();   // add x3,x1,x2
    set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0);           // sub x4,x3,x3
    #1;
    total++; if (stall !== 1'b0) $display("FAIL alu_no_stall: got %b expected 0", stall); else passed++;
    tick();
    total++; if (ex_sel !== 4'b1010) $display("FAIL alu_dist1_sel: got %b expected %b", ex_sel, 4'b1010); else passed++;
    drain();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0); tick();
    nop(); tick();
    set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0); tick();
    total++; if (ex_sel !== 4'b0101) $display("FAIL alu_dist2_sel: got %b expected %b", ex_sel, 4'b0101); else passed++;
    drain();
  endtask

  task automatic test_double_hit();
    set_id(1'b1, 5'd1, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd2, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd5, 2'b01, 5'd8, 1'b1, 1'b0); tick();   // src1 names x5 but is unused
    total++; if (ex_sel !== 4'b0010) $display("FAIL double_hit_sel: got %b expected %b", ex_sel, 4'b0010); else passed++;
    drain();
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, 5'd1, 5'd1, 2'b11, 5'd0, 1'b1, 1'b1); tick();   // lw x0
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL zero_stall: got %b expected 0", stall); else passed++;
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0); tick();
    total++; if (ex_sel !== 4'b0000) $display("FAIL zero_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1); tick();   // lw x6
    set_id(1'b1, 5'd6, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);           // add x7,x6,x1
    #1;
    total++; if (stall !== 1'b1) $display("FAIL lu_stall_on: got %b expected 1", stall); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL lu_cnt_before: got %0d expected 0", stall_cnt); else passed++;
    tick();
    total++; if (stall !== 1'b0) $display("FAIL lu_stall_one_cycle: got %b expected 0", stall); else passed++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt_after: got %0d expected 1", stall_cnt); else passed++;
    total++; if (ex_sel !== 4'b0000) $display("FAIL lu_bubble_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    tick();
    total++; if (ex_sel !== 4'b0001) $display("FAIL lu_consumer_sel: got %b expected %b", ex_sel, 4'b0001); else passed++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt_hold: got %0d expected 1", stall_cnt); else passed++;
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1); tick();   // lw x6
    set_id(1'b1, 5'd6, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall); else passed++;
    tick();
    flush = 1'b0;
    nop();
    total++; if (stall_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d expected 1", stall_cnt); else passed++;
    total++; if (ex_sel !== 4'b0000) $display("FAIL flush_bubble_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    drain();
  endtask

  task automatic test_bypass();
    set_id(1'b1, 5'd1, 5'd1, 2'b11, 5'd9, 1'b1, 1'b0); tick();   // writer x9
    nop(); tick();
    nop(); tick();
    set_id(1'b1, 5'd9, 5'd9, 2'b01, 5'd10, 1'b1, 1'b0);          // reader, src1 unused
    #1;
    total++; if (id_bypass !== BYP_EXP) $display("FAIL bypass_id: got %b expected %b", id_bypass, BYP_EXP); else passed++;
    tick();
    total++; if (ex_sel !== 4'b0000) $display("FAIL bypass_dist3_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    drain();
  endtask

  task automatic test_midstream_reset();
    set_id(1'b1, 5'd1, 5'd1, 2'b11, 5'd10, 1'b1, 1'b1); tick();  // lw x10
    set_id(1'b1, 5'd10, 5'd10, 2'b11, 5'd11, 1'b1, 1'b0);        // reader of x10
    #1;
    total++; if (stall !== 1'b1) $display("FAIL rst_pre_stall: got %b expected 1", stall); else passed++;
    rst = 1'b1;
    tick();
    total++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall); else passed++;
    total++; if (ex_sel !== 4'b0000) $display("FAIL rst_mid_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL rst_mid_cnt: got %0d expected 0", stall_cnt); else passed++;
    total++; if (id_bypass !== 2'b00) $display("FAIL rst_mid_bypass: got %b expected 00", id_bypass); else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (ex_sel !== 4'b0000) $display("FAIL rst_consumer_sel: got %b expected %b", ex_sel, 4'b0000); else passed++;
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_double_hit();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_bypass();
    test_midstream_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
